// File: rtl/stack_seq_pkg.sv
// rtl/stack_seq_pkg.sv - shared op codes, fault codes and FSM states for the stack sequencer
package stack_seq_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_OVERFLOW  = 2'b01;
    localparam logic [1:0] FAULT_UNDERFLOW = 2'b10;

    localparam int SEQ_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // PUSH and CALL grow the stack; POP and RET shrink it.
    function automatic logic is_push_op(input logic [1:0] code);
        return (code == OP_PUSH) || (code == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_bounds_check.sv
// rtl/stack_bounds_check.sv - full/empty detection and neighbouring SP values
module stack_bounds_check #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] STACK_TOP   = 'h58,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 'h18,
    parameter int                WORD_BYTES  = 4
) (
    input  logic [DATA_W-1:0] sp,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] sp_dec,
    output logic [DATA_W-1:0] sp_inc
);

    localparam logic [DATA_W-1:0] STEP = DATA_W'(WORD_BYTES);

    assign full   = (sp == STACK_LIMIT);
    assign empty  = (sp == STACK_TOP);
    assign sp_dec = sp - STEP;
    assign sp_inc = sp + STEP;

endmodule

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - multi-cycle PUSH/POP/CALL/RET sequencer owning the stack pointer
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] STACK_TOP   = 32'h58,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 32'h18,
    parameter int                WORD_BYTES  = SEQ_WORD_BYTES,
    parameter logic [4:0]        RA_REG      = 5'd31
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] op_data,
    input  logic [4:0]        op_rd,
    input  logic [DATA_W-1:0] ra_value,
    input  logic              sp_load,
    input  logic [DATA_W-1:0] sp_wdata,
    output logic [DATA_W-1:0] sp,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic              fault,
    output logic [1:0]        fault_code
);

    state_t            state, state_n;
    logic [1:0]        code_q, code_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic [4:0]        rd_q, rd_n;

    logic [DATA_W-1:0] sp_n, mem_addr_n, mem_wdata_n, rf_wdata_n;
    logic              mem_req_n, mem_we_n, rf_we_n, done_n, fault_n;
    logic [4:0]        rf_waddr_n;
    logic [1:0]        fault_code_n;

    logic              full, empty;
    logic [DATA_W-1:0] sp_dec, sp_inc;

    stack_bounds_check #(
        .DATA_W     (DATA_W),
        .STACK_TOP  (STACK_TOP),
        .STACK_LIMIT(STACK_LIMIT),
        .WORD_BYTES (WORD_BYTES)
    ) u_bounds (
        .sp    (sp),
        .full  (full),
        .empty (empty),
        .sp_dec(sp_dec),
        .sp_inc(sp_inc)
    );

    assign op_ready = (state == ST_IDLE) && !sp_load && Resetn;

    always_ff @(negedge Clock) begin
        if (!Resetn) begin
            state      <= ST_IDLE;
            code_q     <= OP_PUSH;
            data_q     <= '0;
            rd_q       <= '0;
            sp         <= STACK_TOP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
        end else begin
            state      <= state_n;
            code_q     <= code_n;
            data_q     <= data_n;
            rd_q       <= rd_n;
            sp         <= sp_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            rf_we      <= rf_we_n;
            rf_waddr   <= rf_waddr_n;
            rf_wdata   <= rf_wdata_n;
            done       <= done_n;
            fault      <= fault_n;
            fault_code <= fault_code_n;
        end
    end

    always_comb begin
        state_n      = state;
        code_n       = code_q;
        data_n       = data_q;
        rd_n         = rd_q;
        sp_n         = sp;
        mem_req_n    = mem_req;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        rf_we_n      = 1'b0;
        rf_waddr_n   = rf_waddr;
        rf_wdata_n   = rf_wdata;
        done_n       = 1'b0;
        fault_n      = 1'b0;
        fault_code_n = fault_code;

        unique case (state)
            ST_IDLE: begin
                if (sp_load) begin
                    sp_n = sp_wdata;
                end else if (op_valid && op_ready) begin
                    code_n       = op_code;
                    data_n       = op_data;
                    rd_n         = op_rd;
                    fault_code_n = FAULT_NONE;
                    if (is_push_op(op_code)) begin
                        if (full) begin
                            fault_n      = 1'b1;
                            fault_code_n = FAULT_OVERFLOW;
                            done_n       = 1'b1;
                        end else begin
                            state_n     = ST_MEM;
                            mem_req_n   = 1'b1;
                            mem_we_n    = 1'b1;
                            mem_addr_n  = sp_dec;
                            mem_wdata_n = (op_code == OP_CALL) ? ra_value : op_data;
                        end
                    end else if (empty) begin
                        fault_n      = 1'b1;
                        fault_code_n = FAULT_UNDERFLOW;
                        done_n       = 1'b1;
                    end else begin
                        state_n    = ST_MEM;
                        mem_req_n  = 1'b1;
                        mem_we_n   = 1'b0;
                        mem_addr_n = sp;
                    end
                end
            end
            ST_MEM: begin
                // Request fields are held untouched until the RAM acknowledges.
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    if (mem_we) begin
                        sp_n = sp_dec;
                        if (code_q == OP_CALL) begin
                            state_n    = ST_WB;
                            rf_we_n    = 1'b1;
                            rf_waddr_n = RA_REG;
                            rf_wdata_n = data_q;
                        end else begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        sp_n       = sp_inc;
                        state_n    = ST_WB;
                        rf_waddr_n = (code_q == OP_RET) ? RA_REG : rd_q;
                        rf_wdata_n = mem_rdata;
                        rf_we_n    = (code_q == OP_RET) || (rd_q != 5'd0);
                    end
                end
            end
            ST_WB: begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
